ram_sp_param: RTL and testbench
===============================

Name: ram_sp_param

Overview:
Parametrised single-port synchronous RAM, successor to the fixed 8x8 write-first RAM. Adds configurable width and depth, per-byte write enables, selectable read-during-write mode, an optional output register stage, a read-valid strobe and a hardware clear sequence after reset. Used as generic data/scratch memory next to the CPU pipeline.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of 8
ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH words
RW_MODE, 0, read-during-write: 0 = write-first, 1 = read-first, 2 = no-change
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency
CLEAR_VALUE, 0, word written to every location during the clear sequence

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
ram_ena  input  1  port enable; no access when 0
wena  input  DATA_WIDTH/8  per-byte write enable; bit i covers data bits [8i+7:8i]
addr  input  ADDR_WIDTH  word address
data_in  input  DATA_WIDTH  write data
data_out  output  DATA_WIDTH  read data
data_valid  output  1  high for one cycle when data_out carries the result of an access
init_busy  output  1  high while the clear sequence runs; accesses ignored

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values while rst=1: data_out = 0, data_valid = 0, init_busy = 1, clear counter = 0, FSM in CLEAR.
- FSM states are CLEAR and READY.
- CLEAR:
  - Each cycle writes CLEAR_VALUE to address cnt, then increments cnt.
  - After writing address DEPTH-1, moves to READY, so init_busy is high for exactly DEPTH cycles after rst falls.
  - ram_ena, wena, addr and data_in are ignored; data_out holds 0; data_valid = 0.
- READY: stays in READY until rst is asserted.
- rst asserted mid-clear: the sequence restarts at address 0 on the cycle after rst deasserts. Contents are unspecified until the clear completes.
- Access happens when in READY and ram_ena=1 on a clock edge:
  - Write: each byte i with wena[i]=1 takes data_in byte i; other bytes keep their value.
  - Read: any access, write or not, produces a read result per RW_MODE.
  - ram_ena=0: memory unchanged; data_out holds its last value; data_valid = 0.
- Read-during-write, same edge, same address:
  - RW_MODE 0 (write-first): result is the merged post-write word.
  - RW_MODE 1 (read-first): result is the pre-write word.
  - RW_MODE 2 (no-change):
    - If any wena bit is set, data_out holds and data_valid = 0.
    - If wena = 0, it is a pure read: result is the stored word and data_valid pulses.
- Latency:
  - OUT_REG=0: data_out and data_valid update at the access edge.
  - OUT_REG=1: both pass through one more register, updating one edge later. The output register resets to 0 and holds when no valid result arrives.
- Back-to-back accesses every cycle are supported at full throughput in all modes.
- data_valid is never high while init_busy is high, including the OUT_REG=1 pipeline stage.
- Addresses wrap naturally within ADDR_WIDTH bits; no out-of-range case exists.
- DATA_WIDTH not a multiple of 8 is a configuration error. Flag it with an elaboration-time check.

Test Plan:
- Defaults (8x8, mode 0, OUT_REG 0): pulse rst 1 cycle -> init_busy high exactly 8 cycles, then 0. Read addr 5 -> data_out = 0x00, data_valid pulses once.
- Defaults, write-first: wena=1, addr 0, data_in 8'd3 -> data_out = 3 at that same edge. Then wena=0, read addr 0 -> 3. Read addr 1 -> 0.
- RW_MODE=1: addr 2 holds 0x11. Write 0x5A to addr 2 -> data_out = 0x11. Next read of addr 2 -> 0x5A.
- RW_MODE=2: data_out = 0x11 from a prior read. Write 0x77 -> data_out stays 0x11, data_valid = 0. Next read -> 0x77.
- DATA_WIDTH=16, OUT_REG=1: addr 3 = 0x1234. Write wena=2'b01, data_in 0xABCD -> memory 0x12CD. A read issued on cycle N returns data_out = 0x12CD with data_valid on edge N+2.
- Reset mid-clear: assert rst at clear cycle 4 -> after release, init_busy high a full DEPTH cycles again. All addresses read CLEAR_VALUE (e.g. 0xA5 with CLEAR_VALUE=8'hA5). Accesses attempted during busy leave no change and give data_valid = 0.

Source files
------------

// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM: byte write enables, selectable
// read-during-write behaviour, optional output register and a clear sequence after reset.
module ram_sp_param #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 3,
    parameter int                    RW_MODE     = 0,
    parameter int                    OUT_REG     = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ram_ena,
    input  logic [DATA_WIDTH/8-1:0] wena,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    init_busy
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("ram_sp_param: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (RW_MODE < 0 || RW_MODE > 2) begin : g_bad_mode
        $error("ram_sp_param: RW_MODE must be 0, 1 or 2");
    end

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_busy;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_dout1;
    logic                    r_valid1;

    logic [DATA_WIDTH-1:0]   w_old;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_acc;
    logic                    w_wr;
    logic                    w_rd_valid;
    logic                    w_clr_we;

    // Access decode, byte merge and read-during-write result selection
    always_comb begin
        w_old    = r_mem[addr];
        w_merged = w_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (wena[i]) begin
                w_merged[8*i +: 8] = data_in[8*i +: 8];
            end else begin
                w_merged[8*i +: 8] = w_old[8*i +: 8];
            end
        end
        w_acc    = (r_state == ST_READY) && ram_ena && !rst;
        w_wr     = w_acc && (|wena);
        w_clr_we = (r_state == ST_CLEAR) && !rst;
        if (RW_MODE == 0) begin
            w_rd_data = w_merged;
        end else begin
            w_rd_data = w_old;
        end
        // No-change mode suppresses the result of any write access
        if (RW_MODE == 2) begin
            w_rd_valid = w_acc && !(|wena);
        end else begin
            w_rd_valid = w_acc;
        end
    end

    // Clear/ready sequencer; init_busy drops together with the last clear write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_READY: begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: clear writes take priority over user writes
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= CLEAR_VALUE;
        end else if (w_wr) begin
            r_mem[addr] <= w_merged;
        end
    end

    // First output stage: holds its value when no valid result arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout1  <= '0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid1 <= w_rd_valid;
            if (w_rd_valid) begin
                r_dout1 <= w_rd_data;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] r_dout2;
        logic                  r_valid2;

        // Optional second output stage adding one cycle of latency
        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout2  <= '0;
                r_valid2 <= 1'b0;
            end else begin
                r_valid2 <= r_valid1;
                if (r_valid1) begin
                    r_dout2 <= r_dout1;
                end
            end
        end

        assign data_out   = r_dout2;
        assign data_valid = r_valid2;
    end else begin : g_noreg
        assign data_out   = r_dout1;
        assign data_valid = r_valid1;
    end

    assign init_busy = r_busy;

endmodule

// File: tb/tb_ram_sp_param.sv
// Self-checking bench for ram_sp_param: four configurations share one stimulus
// stream; a word-level reference model plus a hand-derived vector table checks them.
module tb_ram_sp_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_ena;
    logic [1:0]  wena;
    logic [3:0]  addr;
    logic [15:0] data_in;

    logic [7:0]  do0, do1, do2;
    logic [15:0] do3;
    logic        dv0, dv1, dv2, dv3;
    logic        bz0, bz1, bz2, bz3;

    always #5 clk = ~clk;

    ram_sp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RW_MODE(0), .OUT_REG(0), .CLEAR_VALUE(8'h00)) u_d0 (
        .clk(clk), .rst(rst), .ram_ena(ram_ena), .wena(wena[0:0]), .addr(addr[2:0]),
        .data_in(data_in[7:0]), .data_out(do0), .data_valid(dv0), .init_busy(bz0));
    ram_sp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RW_MODE(1), .OUT_REG(0), .CLEAR_VALUE(8'hA5)) u_d1 (
        .clk(clk), .rst(rst), .ram_ena(ram_ena), .wena(wena[0:0]), .addr(addr[2:0]),
        .data_in(data_in[7:0]), .data_out(do1), .data_valid(dv1), .init_busy(bz1));
    ram_sp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .RW_MODE(2), .OUT_REG(0), .CLEAR_VALUE(8'h3C)) u_d2 (
        .clk(clk), .rst(rst), .ram_ena(ram_ena), .wena(wena[0:0]), .addr(addr[2:0]),
        .data_in(data_in[7:0]), .data_out(do2), .data_valid(dv2), .init_busy(bz2));
    ram_sp_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RW_MODE(2), .OUT_REG(1), .CLEAR_VALUE(16'h5A5A)) u_d3 (
        .clk(clk), .rst(rst), .ram_ena(ram_ena), .wena(wena), .addr(addr),
        .data_in(data_in), .data_out(do3), .data_valid(dv3), .init_busy(bz3));

    int          p_dw [4] = '{8, 8, 8, 16};
    int          p_aw [4] = '{3, 3, 3, 4};
    int          p_md [4] = '{0, 1, 2, 2};
    int          p_or [4] = '{0, 0, 0, 1};
    logic [15:0] p_cv [4] = '{16'h0000, 16'h00A5, 16'h003C, 16'h5A5A};

    logic [15:0] m_mem [4][16];
    int          busy_left [4];
    logic [15:0] e_d [4];
    logic        e_v [4];
    logic [15:0] q_d [4];
    logic        q_v [4];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        ena;
        logic [1:0]  we;
        logic [3:0]  a;
        logic [15:0] din;
        logic [7:0]  e0;
        logic        v0;
        logic [7:0]  e1;
        logic        v1;
        logic [7:0]  e2;
        logic        v2;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] act_d(input int k);
        case (k)
            0:       return {8'h00, do0};
            1:       return {8'h00, do1};
            2:       return {8'h00, do2};
            default: return do3;
        endcase
    endfunction

    function automatic logic act_v(input int k);
        case (k)
            0:       return dv0;
            1:       return dv1;
            2:       return dv2;
            default: return dv3;
        endcase
    endfunction

    function automatic logic act_b(input int k);
        case (k)
            0:       return bz0;
            1:       return bz1;
            2:       return bz2;
            default: return bz3;
        endcase
    endfunction

    // Reference model: advance every configuration by one clock edge
    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            int          depth;
            int          a;
            logic [15:0] msk, old_w, new_w, res_d;
            logic [1:0]  wem;
            logic        res_v;
            depth = 1 << p_aw[k];
            msk   = (p_dw[k] == 8) ? 16'h00FF : 16'hFFFF;
            wem   = (p_dw[k] == 8) ? (wena & 2'b01) : wena;
            a     = int'(addr) % depth;
            if (rst) begin
                busy_left[k] = depth;
                e_d[k] = 16'h0000; e_v[k] = 1'b0;
                q_d[k] = 16'h0000; q_v[k] = 1'b0;
            end else if (busy_left[k] > 0) begin
                busy_left[k]--;
                if (busy_left[k] == 0) begin
                    for (int j = 0; j < depth; j++) m_mem[k][j] = p_cv[k];
                end
                e_v[k] = 1'b0;
                q_v[k] = 1'b0;
            end else begin
                old_w = m_mem[k][a];
                new_w = old_w;
                if (wem[0]) new_w[7:0]  = data_in[7:0];
                if (wem[1]) new_w[15:8] = data_in[15:8];
                new_w = new_w & msk;
                res_v = ram_ena && (p_md[k] != 2 || wem == 2'b00);
                res_d = (p_md[k] == 0) ? new_w : old_w;
                if (ram_ena && wem != 2'b00) m_mem[k][a] = new_w;
                if (p_or[k] != 0) begin
                    e_v[k] = q_v[k];
                    if (q_v[k]) e_d[k] = q_d[k];
                    q_v[k] = res_v;
                    if (res_v) q_d[k] = res_d;
                end else begin
                    e_v[k] = res_v;
                    if (res_v) e_d[k] = res_d;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("d%0d_data", k), act_d(k), e_d[k]);
            chk($sformatf("d%0d_valid", k), {15'd0, act_v(k)}, {15'd0, e_v[k]});
            chk($sformatf("d%0d_busy", k), {15'd0, act_b(k)}, {15'd0, (busy_left[k] > 0)});
        end
    endtask

    task automatic rand_inputs();
        ram_ena = ($urandom_range(0, 3) != 0);
        wena    = ($urandom_range(0, 1) != 0) ? 2'($urandom) : 2'b00;
        addr    = 4'($urandom);
        data_in = 16'($urandom);
    endtask

    initial begin
        int cnt;
        //          ena   we     a     din       e0     v0    e1     v1    e2     v2
        tbl[0] = '{1'b1, 2'b01, 4'd0, 16'h0003, 8'h03, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 2'b00, 4'd0, 16'h0000, 8'h03, 1'b1, 8'h03, 1'b1, 8'h03, 1'b1};
        tbl[2] = '{1'b1, 2'b00, 4'd1, 16'h0000, 8'h00, 1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1};
        tbl[3] = '{1'b1, 2'b01, 4'd2, 16'h0011, 8'h11, 1'b1, 8'hA5, 1'b1, 8'h3C, 1'b0};
        tbl[4] = '{1'b1, 2'b01, 4'd2, 16'h005A, 8'h5A, 1'b1, 8'h11, 1'b1, 8'h3C, 1'b0};
        tbl[5] = '{1'b1, 2'b00, 4'd2, 16'h0000, 8'h5A, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1};
        tbl[6] = '{1'b0, 2'b01, 4'd2, 16'h00FF, 8'h5A, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b0};
        tbl[7] = '{1'b1, 2'b00, 4'd2, 16'h0000, 8'h5A, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1};
        tbl[8] = '{1'b1, 2'b00, 4'd5, 16'h0000, 8'h00, 1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1};
        tbl[9] = '{1'b0, 2'b00, 4'd5, 16'h0000, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h3C, 1'b0};

        rst = 1'b1; ram_ena = 1'b0; wena = 2'b00; addr = 4'd0; data_in = 16'h0000;
        step();
        step();
        rst = 1'b0;
        cnt = 0;
        while (bz0 && cnt < 40) begin
            step();
            cnt++;
        end
        chk("busy_len_d0", 16'(cnt), 16'd8);
        repeat (8) step();

        // Hand-derived vectors for the three 8-bit read-during-write modes
        for (int i = 0; i < 10; i++) begin
            ram_ena = tbl[i].ena; wena = tbl[i].we; addr = tbl[i].a; data_in = tbl[i].din;
            step();
            chk($sformatf("tbl%0d_d0", i), {7'd0, dv0, do0}, {7'd0, tbl[i].v0, tbl[i].e0});
            chk($sformatf("tbl%0d_d1", i), {7'd0, dv1, do1}, {7'd0, tbl[i].v1, tbl[i].e1});
            chk($sformatf("tbl%0d_d2", i), {7'd0, dv2, do2}, {7'd0, tbl[i].v2, tbl[i].e2});
        end

        // 16-bit partial write through the extra output register
        ram_ena = 1'b1; addr = 4'd3; wena = 2'b11; data_in = 16'h1234; step();
        wena = 2'b01; data_in = 16'hABCD; step();
        wena = 2'b00; step();
        chk("d3_lat_early_valid", {15'd0, dv3}, 16'd0);
        ram_ena = 1'b0; step();
        chk("d3_lat_data", do3, 16'h12CD);
        chk("d3_lat_valid", {15'd0, dv3}, 16'd1);

        // Reset in the middle of a clear sequence, with accesses attempted while busy
        rst = 1'b1; step();
        rst = 1'b0; repeat (4) step();
        rst = 1'b1; step();
        rst = 1'b0;
        cnt = 0;
        while (bz0 && cnt < 40) begin
            rand_inputs();
            step();
            cnt++;
        end
        chk("busy_len_restart", 16'(cnt), 16'd8);
        ram_ena = 1'b0; wena = 2'b00;
        repeat (8) step();
        for (int a = 0; a < 16; a++) begin
            ram_ena = 1'b1; wena = 2'b00; addr = 4'(a);
            step();
            chk($sformatf("clr_d0_a%0d", a), {8'h00, do0}, 16'h0000);
            chk($sformatf("clr_d1_a%0d", a), {8'h00, do1}, 16'h00A5);
            chk($sformatf("clr_d2_a%0d", a), {8'h00, do2}, 16'h003C);
        end

        // Randomised traffic with occasional resets, checked by the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            rand_inputs();
            step();
        end
        rst = 1'b0; ram_ena = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
